lc3_datapath_p: RTL
===================

# lc3_datapath_p

Parametrised successor to the single-width LC-3 datapath. It holds PC, MAR, MDR, IR, an 8-entry general register file, the ALU, the NZP condition codes, the BEN flag and an LED latch, all joined by one internal CPU bus. The bus is built as a one-hot-gated mux rather than tristates. The block sits between the control FSM (which drives every LD_*, Gate* and mux select) and the memory/IO interface (MAR/MDR/MDR_In).

## Interface
Parameters:
- WIDTH, 16, datapath width; must be ≥16. Instruction fields use fixed LC-3 positions, and immediates are sign-extended to WIDTH.
- RESET_PC, 0, PC value on reset.
- LED_W, 12, width of the LED latch; must be ≤ WIDTH.

Ports:
- Clk  in  1  sole clock.
- Reset  in  1  asynchronous, active-low reset.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus source gates.
- PCMUX, ADDR2MUX, ALUK  in  2 each  selects.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN  in  1 each  selects.
- MDR_In  in  WIDTH  read data from the memory interface.
- Bus  out  WIDTH  current CPU bus value.
- MAR, MDR, IR, PC  out  WIDTH  architectural registers.
- BEN  out  1  branch-enable flag.
- NZP  out  3  condition codes {N,Z,P}.
- LED  out  LED_W  LED latch.
- Bus_Err  out  1  sticky multi-driver flag. Present only when the configuration macro is defined.

## Operation
Bus:
- Bus source is selected by the active gate: GatePC→PC, GateMDR→MDR, GateALU→ALU result, GateMARMUX→ADDR_sum.
- With no gate active, Bus = 0.
- With more than one gate active, priority is PC > MDR > ALU > MARMUX.

Address adder:
- ADDR_sum = ADDR1 + ADDR2, modulo 2^WIDTH.
- ADDR1MUX: 0 → PC, 1 → SR1 data.
- ADDR2MUX: 0 → 0, 1 → sext(IR[5:0]), 2 → sext(IR[8:0]), 3 → sext(IR[10:0]).

Register file:
- SR1 address: SR1MUX 0 → IR[11:9], 1 → IR[8:6].
- SR2 address: IR[2:0].
- DR address: DRMUX 0 → IR[11:9], 1 → 3'd7.
- Reads are combinational. The write of Bus to DR happens on the clock edge when LD_REG is high.
- There is no write-to-read bypass: a same-cycle read returns the old value.

ALU:
- A input = SR1 data.
- B input: SR2MUX 0 → sext(IR[4:0]), 1 → SR2 data.
- ALUK: 0 ADD (modulo), 1 AND, 2 NOT A, 3 PASS A.

Register loads (on the clock edge):
- PC, when LD_PC. PCMUX: 0 → PC+1 (wraps), 1 → Bus, 2 → ADDR_sum, 3 → hold.
- MAR ← Bus, when LD_MAR.
- MDR, when LD_MDR: MIO_EN=1 → MDR_In, MIO_EN=0 → Bus.
- IR ← Bus, when LD_IR.
- LED ← IR[LED_W-1:0], when LD_LED.

Condition codes (on LD_CC):
- N = Bus[WIDTH-1]; Z = (Bus == 0); P = neither. Exactly one bit is set.

BEN (on LD_BEN):
- BEN ← (IR[11]&N) | (IR[10]&Z) | (IR[9]&P).
- Uses the current registered IR and NZP, not values loaded in the same cycle.

## Timing
Reset values, applied immediately and asynchronously while Reset is low:
- PC = RESET_PC.
- MAR, MDR, IR, all registers R0–R7 = 0.
- NZP = 3'b010.
- BEN = 0, LED = 0, Bus_Err = 0.

Combinational paths:
- Bus, ADDR_sum and the ALU result are purely combinational from the current register state and the selects, within the same cycle.

Load latency and ordering:
- Every load has one-cycle latency: a value driven on Bus in cycle t is visible on the target output after the edge ending cycle t.
- Simultaneous loads (e.g. LD_IR with LD_BEN, LD_REG with LD_CC) all sample pre-edge values.

Reset and wrap-around:
- Reset asserted mid-operation overrides every load in that cycle.
- Reset release is taken at the next edge and needs no synchronizer inside the block.
- PC = all-ones with PCMUX=0 wraps to 0.

## Configuration
- With DATAPATH_BUS_CHECK_EN defined:
  - Bus_Err exists.
  - It is set at the clock edge of any cycle in which two or more gates are active.
  - It stays set until reset.
  - A simulation-only assertion also fires in that cycle.
- Without the macro: the port and the logic are absent, and multi-gate cycles resolve silently by priority.

## Structure
- Shared package lc3_datapath_pkg holds:
  - alu_op_e {ADD, AND, NOT, PASSA}
  - pcmux_e {PC_INC, PC_BUS, PC_ADDR, PC_HOLD}
  - addr2mux_e
  - the NZP reset constant
  - a sext function parametrised on WIDTH
- One sub-module: lc3_reg_file (8×WIDTH, 2 combinational read ports, 1 synchronous write port, async active-low reset).

## Test plan
- Reset low mid-run with RESET_PC=16'h3000 → PC=3000, NZP=010, all other outputs 0 immediately.
- Load IR=16'h1262 via the bus (ADD R1,R1,#2), with R1=5 beforehand. Then GateALU, SR2MUX=0, LD_REG, LD_CC → R1=7, NZP=001.
- IR=16'h0A05 (BRnp) with NZP=100, then LD_BEN → BEN=1. Repeat with NZP=010 → BEN=0.
- PC=16'h3000, IR offset9=-1 (1FF), ADDR1MUX=0, ADDR2MUX=2, PCMUX=2, LD_PC → PC=2FFF. Then PC=FFFF with PCMUX=0 → PC=0000.
- MIO_EN=1, MDR_In=16'hBEEF, LD_MDR, then GateMDR+LD_CC → MDR=BEEF, NZP=100.
- GatePC and GateMDR together → Bus=PC. Bus_Err=1 next cycle with the macro, port absent without it.

Source files
------------

// File: rtl/lc3_datapath_pkg.sv
// Shared types and helpers for the parametrised LC-3 datapath.
package lc3_datapath_pkg;

   typedef enum logic [1:0] {
      ADD   = 2'd0,
      AND   = 2'd1,
      NOT   = 2'd2,
      PASSA = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_INC  = 2'd0,
      PC_BUS  = 2'd1,
      PC_ADDR = 2'd2,
      PC_HOLD = 2'd3
   } pcmux_e;

   typedef enum logic [1:0] {
      A2_ZERO  = 2'd0,
      A2_OFF6  = 2'd1,
      A2_OFF9  = 2'd2,
      A2_OFF11 = 2'd3
   } addr2mux_e;

   localparam logic [2:0] NZP_RESET = 3'b010;

   // Widest datapath the sign-extender supports; callers size-cast down to WIDTH.
   localparam int unsigned SEXT_W = 64;

   // Sign-extends the low fw bits of field (fw in 1..11) to SEXT_W bits.
   function automatic logic [SEXT_W-1:0] sext(input logic [10:0] field,
                                              input int unsigned fw);
      logic signed [SEXT_W-1:0] t;
      t = $signed({{(SEXT_W-11){1'b0}}, field} << (SEXT_W - fw));
      return t >>> (SEXT_W - fw);
   endfunction

endpackage

// File: rtl/lc3_reg_file.sv
// 8 x WIDTH general register file: two combinational read ports, one
// synchronous write port, no write-to-read bypass.
module lc3_reg_file
   import lc3_datapath_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic [2:0]       waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [2:0]       raddr1_i,
   input  logic [2:0]       raddr2_i,
   output logic [WIDTH-1:0] rdata1_o,
   output logic [WIDTH-1:0] rdata2_o
);

   logic [WIDTH-1:0] regs_q [8];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = regs_q[raddr1_i];
   assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/lc3_datapath_p.sv
// Parametrised LC-3 datapath: PC/MAR/MDR/IR, register file, ALU, NZP, BEN, LED
// on one gated CPU bus. Define DATAPATH_BUS_CHECK_EN to add the sticky Bus_Err flag.
module lc3_datapath_p
   import lc3_datapath_pkg::*;
#(
   parameter int              WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int              LED_W    = 12
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LD_MAR,
   input  logic             LD_MDR,
   input  logic             LD_IR,
   input  logic             LD_BEN,
   input  logic             LD_CC,
   input  logic             LD_REG,
   input  logic             LD_PC,
   input  logic             LD_LED,
   input  logic             GatePC,
   input  logic             GateMDR,
   input  logic             GateALU,
   input  logic             GateMARMUX,
   input  logic [1:0]       PCMUX,
   input  logic [1:0]       ADDR2MUX,
   input  logic [1:0]       ALUK,
   input  logic             DRMUX,
   input  logic             SR1MUX,
   input  logic             SR2MUX,
   input  logic             ADDR1MUX,
   input  logic             MIO_EN,
   input  logic [WIDTH-1:0] MDR_In,
   output logic [WIDTH-1:0] Bus,
   output logic [WIDTH-1:0] MAR,
   output logic [WIDTH-1:0] MDR,
   output logic [WIDTH-1:0] IR,
   output logic [WIDTH-1:0] PC,
   output logic             BEN,
   output logic [2:0]       NZP,
`ifdef DATAPATH_BUS_CHECK_EN
   output logic             Bus_Err,
`endif
   output logic [LED_W-1:0] LED
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] mar_q, mar_d;
   logic [WIDTH-1:0] mdr_q, mdr_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [2:0]       nzp_q, nzp_d;
   logic             ben_q, ben_d;
   logic [LED_W-1:0] led_q, led_d;

   logic [WIDTH-1:0] bus;
   logic [WIDTH-1:0] sr1_data, sr2_data;
   logic [2:0]       sr1_addr, sr2_addr, dr_addr;
   logic [WIDTH-1:0] addr1, addr2, addr_sum;
   logic [WIDTH-1:0] alu_b, alu_out;
   logic [WIDTH-1:0] off5, off6, off9, off11;

   assign off5  = WIDTH'(sext(ir_q[10:0], 5));
   assign off6  = WIDTH'(sext(ir_q[10:0], 6));
   assign off9  = WIDTH'(sext(ir_q[10:0], 9));
   assign off11 = WIDTH'(sext(ir_q[10:0], 11));

   assign sr1_addr = SR1MUX ? ir_q[8:6] : ir_q[11:9];
   assign sr2_addr = ir_q[2:0];
   assign dr_addr  = DRMUX ? 3'd7 : ir_q[11:9];

   lc3_reg_file #(
      .WIDTH (WIDTH)
   ) u_reg_file (
      .clk_i    (Clk),
      .rst_ni   (Reset),
      .we_i     (LD_REG),
      .waddr_i  (dr_addr),
      .wdata_i  (bus),
      .raddr1_i (sr1_addr),
      .raddr2_i (sr2_addr),
      .rdata1_o (sr1_data),
      .rdata2_o (sr2_data)
   );

   // Address adder (MARMUX source and PC branch target)
   assign addr1 = ADDR1MUX ? sr1_data : pc_q;

   always_comb begin
      addr2 = '0;
      case (addr2mux_e'(ADDR2MUX))
         A2_ZERO:  addr2 = '0;
         A2_OFF6:  addr2 = off6;
         A2_OFF9:  addr2 = off9;
         A2_OFF11: addr2 = off11;
      endcase
   end

   assign addr_sum = addr1 + addr2;

   assign alu_b = SR2MUX ? sr2_data : off5;

   always_comb begin
      alu_out = '0;
      case (alu_op_e'(ALUK))
         ADD:   alu_out = sr1_data + alu_b;
         AND:   alu_out = sr1_data & alu_b;
         NOT:   alu_out = ~sr1_data;
         PASSA: alu_out = sr1_data;
      endcase
   end

   // Gated bus mux; overlapping gates resolve by fixed priority.
   always_comb begin
      bus = '0;
      if (GatePC)          bus = pc_q;
      else if (GateMDR)    bus = mdr_q;
      else if (GateALU)    bus = alu_out;
      else if (GateMARMUX) bus = addr_sum;
   end

   always_comb begin
      pc_d = pc_q;
      if (LD_PC) begin
         case (pcmux_e'(PCMUX))
            PC_INC:  pc_d = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
            PC_BUS:  pc_d = bus;
            PC_ADDR: pc_d = addr_sum;
            PC_HOLD: pc_d = pc_q;
         endcase
      end
   end

   always_comb begin
      mar_d = LD_MAR ? bus : mar_q;
      mdr_d = mdr_q;
      if (LD_MDR) mdr_d = MIO_EN ? MDR_In : bus;
      ir_d  = LD_IR ? bus : ir_q;
      led_d = LD_LED ? ir_q[LED_W-1:0] : led_q;
   end

   // Exactly one of N/Z/P is set for any bus value.
   always_comb begin
      nzp_d = nzp_q;
      if (LD_CC) begin
         nzp_d[2] = bus[WIDTH-1];
         nzp_d[1] = (bus == '0);
         nzp_d[0] = !bus[WIDTH-1] && (bus != '0);
      end
   end

   // Uses registered IR/NZP so same-edge loads of those do not feed through.
   always_comb begin
      ben_d = ben_q;
      if (LD_BEN)
         ben_d = (ir_q[11] & nzp_q[2]) | (ir_q[10] & nzp_q[1]) | (ir_q[9] & nzp_q[0]);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_q  <= RESET_PC;
         mar_q <= '0;
         mdr_q <= '0;
         ir_q  <= '0;
         nzp_q <= NZP_RESET;
         ben_q <= 1'b0;
         led_q <= '0;
      end else begin
         pc_q  <= pc_d;
         mar_q <= mar_d;
         mdr_q <= mdr_d;
         ir_q  <= ir_d;
         nzp_q <= nzp_d;
         ben_q <= ben_d;
         led_q <= led_d;
      end
   end

`ifdef DATAPATH_BUS_CHECK_EN
   logic bus_err_q, bus_err_d;
   logic multi_gate;

   assign multi_gate = $countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1;
   assign bus_err_d  = bus_err_q | multi_gate;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) bus_err_q <= 1'b0;
      else        bus_err_q <= bus_err_d;
   end

   assign Bus_Err = bus_err_q;

`ifndef SYNTHESIS
   always @(posedge Clk) begin
      if (Reset) assert (!multi_gate) else $error("bus contention: more than one gate active");
   end
`endif
`endif

   assign Bus = bus;
   assign PC  = pc_q;
   assign MAR = mar_q;
   assign MDR = mdr_q;
   assign IR  = ir_q;
   assign NZP = nzp_q;
   assign BEN = ben_q;
   assign LED = led_q;

endmodule
